// File: rtl/datapath_legv8_pkg.sv
// rtl/datapath_legv8_pkg.sv - shared constants and ALU op encodings for the LEGv8 datapath
package datapath_legv8_pkg;

  localparam int DATA_W    = 64;
  localparam int RAM_AW    = 8;
  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int NUM_REGS  = 32;
  localparam int SHAMT_W   = 6;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_LSL = 3'b100,
    OP_LSR = 3'b101
  } alu_op_e;

endpackage

// File: rtl/alu_legv8.sv
// rtl/alu_legv8.sv - 64-bit LEGv8 ALU with operand inversion and {V,C,N,Z} flags
module alu_legv8
  import datapath_legv8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        fs,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic              carry;
  logic              ovf;
  logic              big_shift;
  alu_op_e           op;

  always_comb begin
    op        = alu_op_e'(fs[4:2]);
    op_a      = fs[1] ? ~a : a;
    op_b      = fs[0] ? ~b : b;
    sum       = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
    // Any amount of 64 or more shifts every bit out.
    big_shift = |op_b[DATA_W-1:SHAMT_W];
    result    = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    case (op)
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_XOR: result = op_a ^ op_b;
      OP_LSL: result = big_shift ? '0 : (op_a << op_b[SHAMT_W-1:0]);
      OP_LSR: result = big_shift ? '0 : (op_a >> op_b[SHAMT_W-1:0]);
      default: result = '0;
    endcase
    flags = {ovf, carry, result[DATA_W-1], (result == '0)};
  end

endmodule

// File: rtl/datapath_legv8.sv
// rtl/datapath_legv8.sv - LEGv8 datapath: 32x64 register file, ALU, 256x64 RAM and bus mux
module datapath_legv8
  import datapath_legv8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        DA,
  input  logic [4:0]        SA,
  input  logic [4:0]        SB,
  input  logic              W_reg,
  input  logic [4:0]        FS,
  input  logic              c_out,
  input  logic [DATA_W-1:0] k,
  input  logic              B_sel,
  input  logic [RAM_AW-1:0] addr,
  input  logic              W_ram,
  input  logic              ram_en,
  input  logic              alu_en,
  input  logic              D_en,
  input  logic              B_en,
  output logic [DATA_W-1:0] f,
  output logic [3:0]        stat,
  output logic [15:0]       r0,
  output logic [15:0]       r1,
  output logic [15:0]       r2,
  output logic [15:0]       r3,
  output logic [15:0]       r4,
  output logic [15:0]       r5,
  output logic [15:0]       r6,
  output logic [15:0]       r7
);

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] ram_rdata;
  logic [RAM_AW-1:0] ram_addr;

  always_comb begin
    a_data    = (SA == XZR) ? '0 : rf_q[SA];
    b_data    = (SB == XZR) ? '0 : rf_q[SB];
    alu_b     = B_sel ? k : b_data;
    ram_addr  = ram_en ? alu_result[RAM_AW-1:0] : addr;
    ram_rdata = mem_q[ram_addr];
    if (alu_en)     f = alu_result;
    else if (D_en)  f = ram_rdata;
    else if (B_en)  f = b_data;
    else            f = '0;
  end

  alu_legv8 u_alu (
    .a      (a_data),
    .b      (alu_b),
    .fs     (FS),
    .cin    (c_out),
    .result (alu_result),
    .flags  (stat)
  );

  always_comb begin
    rf_d = rf_q;
    if (W_reg && (DA != XZR)) rf_d[DA] = f;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // RAM has no reset, so a store during reset still lands.
  always_ff @(posedge clk) begin
    if (W_ram) mem_q[ram_addr] <= f;
  end

  assign r0 = rf_q[0][15:0];
  assign r1 = rf_q[1][15:0];
  assign r2 = rf_q[2][15:0];
  assign r3 = rf_q[3][15:0];
  assign r4 = rf_q[4][15:0];
  assign r5 = rf_q[5][15:0];
  assign r6 = rf_q[6][15:0];
  assign r7 = rf_q[7][15:0];

endmodule

// File: tb/tb_datapath_legv8.sv
// tb/tb_datapath_legv8.sv - self-checking bench for datapath_legv8 against a behavioural model
module tb_datapath_legv8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  DA, SA, SB, FS;
  logic        W_reg, c_out, B_sel, W_ram, ram_en, alu_en, D_en, B_en;
  logic [63:0] k;
  logic [7:0]  addr;
  logic [63:0] f;
  logic [3:0]  stat;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  int total = 0;
  int bad   = 0;

  logic [63:0] mrf [32];
  logic [63:0] mmem [256];

  datapath_legv8 dut (
    .clk(clk), .rst(rst), .DA(DA), .SA(SA), .SB(SB), .W_reg(W_reg),
    .FS(FS), .c_out(c_out), .k(k), .B_sel(B_sel), .addr(addr),
    .W_ram(W_ram), .ram_en(ram_en), .alu_en(alu_en), .D_en(D_en), .B_en(B_en),
    .f(f), .stat(stat), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .r4(r4), .r5(r5), .r6(r6), .r7(r7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    DA = 5'd0; SA = 5'd31; SB = 5'd31; FS = 5'd0; W_reg = 1'b0; c_out = 1'b0;
    k = '0; B_sel = 1'b0; addr = '0; W_ram = 1'b0; ram_en = 1'b0;
    alu_en = 1'b0; D_en = 1'b0; B_en = 1'b0;
  endtask

  // Load an immediate into a register through XZR + k.
  task automatic load_imm(input logic [4:0] dst, input logic [63:0] val);
    idle();
    SA = 5'd31; k = val; B_sel = 1'b1; FS = 5'b01000; alu_en = 1'b1;
    W_reg = 1'b1; DA = dst;
    tick();
    if (dst != 5'd31) mrf[dst] = val;
    idle();
  endtask

  // Returns {V, C, N, Z, result}.
  function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] fs, input logic cin);
    logic [63:0]        x, y, r;
    logic [64:0]        wide;
    logic signed [65:0] sw, smax, smin;
    logic               c, v;
    x = fs[1] ? ~a : a;
    y = fs[0] ? ~b : b;
    c = 1'b0;
    v = 1'b0;
    smax = 66'sd9223372036854775807;
    smin = -smax - 66'sd1;
    case (fs[4:2])
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        wide = {1'b0, x} + {1'b0, y} + {64'd0, cin};
        r    = wide[63:0];
        c    = wide[64];
        sw   = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, cin});
        v    = (sw > smax) || (sw < smin);
      end
      3'd3: r = x ^ y;
      3'd4: r = x << y;
      3'd5: r = x >> y;
      default: r = '0;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  initial begin
    logic [63:0] ra, rb, fexp, mres, v;
    logic [67:0] ares;
    logic [7:0]  maddr;
    logic [63:0] fp, fc, fn;

    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mrf[i] = '0;

    // Fill every RAM word so all later reads are known.
    for (int i = 0; i < 256; i++) begin
      idle();
      v = {$urandom, $urandom};
      SA = 5'd31; k = v; B_sel = 1'b1; FS = 5'b01000; alu_en = 1'b1;
      W_ram = 1'b1; addr = 8'(i);
      tick();
      mmem[i] = v;
    end
    idle();

    // Random register writes, then asynchronous reset.
    for (int i = 0; i < 8; i++) load_imm(5'(i), {$urandom, $urandom} | 64'h1);
    chk("pre_reset_r3", {48'd0, r3}, {48'd0, mrf[3][15:0]});
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    chk("reset_r0_3", {r3, r2, r1, r0}, 64'd0);
    chk("reset_r4_7", {r7, r6, r5, r4}, 64'd0);
    chk("reset_f", f, 64'd0);

    // Writes during reset: register suppressed, RAM allowed.
    SA = 5'd31; k = 64'h77; B_sel = 1'b1; FS = 5'b01000; alu_en = 1'b1;
    W_reg = 1'b1; DA = 5'd1; W_ram = 1'b1; addr = 8'd5;
    tick();
    mmem[5] = 64'h77;
    chk("reset_wr_r1", {48'd0, r1}, 64'd0);
    idle();
    rst = 1'b1;
    D_en = 1'b1; addr = 8'd5;
    #1;
    chk("reset_ram_wr", f, 64'h77);
    idle();

    // Store immediate.
    SA = 5'd31; k = 64'd1; FS = 5'b01000; B_sel = 1'b1; alu_en = 1'b1;
    W_ram = 1'b1; addr = 8'd0;
    #1;
    chk("st_imm_f", f, 64'd1);
    chk("st_imm_stat", {60'd0, stat}, 64'd0);
    tick();
    mmem[0] = 64'd1;
    idle();

    // Load to register.
    D_en = 1'b1; addr = 8'd0; W_reg = 1'b1; DA = 5'd0;
    tick();
    mrf[0] = 64'd1;
    chk("ld_r0", {48'd0, r0}, 64'd1);
    idle();

    // Fibonacci: X1 = X1 + X0 alternating destination.
    fp = 64'd0; fc = 64'd1;
    for (int i = 0; i < 10; i++) begin
      SA = 5'd1; SB = 5'd0; FS = 5'b01000; B_sel = 1'b0; alu_en = 1'b1;
      W_reg = 1'b1; DA = (i % 2 == 0) ? 5'd1 : 5'd0;
      tick();
      fn = fp + fc;
      fp = fc; fc = fn;
      mrf[DA] = fn;
      chk($sformatf("fib_%0d", i), {48'd0, (DA == 5'd1) ? r1 : r0}, {48'd0, fn[15:0]});
    end
    idle();

    // Subtract to zero.
    load_imm(5'd2, 64'd5);
    SA = 5'd2; k = 64'd5; FS = 5'b01001; c_out = 1'b1; B_sel = 1'b1; alu_en = 1'b1;
    #1;
    chk("sub_f", f, 64'd0);
    chk("sub_stat", {60'd0, stat}, 64'b0101);
    idle();

    // Signed overflow.
    load_imm(5'd3, 64'h7FFF_FFFF_FFFF_FFFF);
    SA = 5'd3; k = 64'd1; FS = 5'b01000; B_sel = 1'b1; alu_en = 1'b1;
    #1;
    chk("ovf_f", f, 64'h8000_0000_0000_0000);
    chk("ovf_stat", {60'd0, stat}, 64'b1010);
    idle();

    // XZR write is discarded.
    load_imm(5'd31, 64'hDEAD_BEEF);
    SA = 5'd31; FS = 5'b01000; B_sel = 1'b0; SB = 5'd31; alu_en = 1'b1;
    #1;
    chk("xzr_alu", f, 64'd0);
    alu_en = 1'b0; B_en = 1'b1;
    #1;
    chk("xzr_b", f, 64'd0);
    idle();

    // Randomized operations against the model.
    for (int it = 0; it < 60; it++) begin
      SA = 5'($urandom_range(0, 31)); SB = 5'($urandom_range(0, 31));
      DA = 5'($urandom_range(0, 31)); FS = 5'($urandom_range(0, 31));
      c_out = 1'($urandom_range(0, 1)); B_sel = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
      addr = 8'($urandom_range(0, 255)); ram_en = 1'($urandom_range(0, 1));
      alu_en = 1'($urandom_range(0, 1)); D_en = 1'($urandom_range(0, 1));
      B_en = 1'($urandom_range(0, 1)); W_reg = 1'($urandom_range(0, 1));
      W_ram = 1'($urandom_range(0, 1));
      #1;
      ra = (SA == 5'd31) ? 64'd0 : mrf[SA];
      rb = (SB == 5'd31) ? 64'd0 : mrf[SB];
      ares = ref_alu(ra, B_sel ? k : rb, FS, c_out);
      mres = ares[63:0];
      maddr = ram_en ? mres[7:0] : addr;
      if (alu_en)     fexp = mres;
      else if (D_en)  fexp = mmem[maddr];
      else if (B_en)  fexp = rb;
      else            fexp = 64'd0;
      chk($sformatf("rand_f_%0d", it), f, fexp);
      chk($sformatf("rand_stat_%0d", it), {60'd0, stat}, {60'd0, ares[67:64]});
      tick();
      if (W_ram) mmem[maddr] = fexp;
      if (W_reg && DA != 5'd31) mrf[DA] = fexp;
      chk($sformatf("rand_r03_%0d", it), {r3, r2, r1, r0},
          {mrf[3][15:0], mrf[2][15:0], mrf[1][15:0], mrf[0][15:0]});
      chk($sformatf("rand_r47_%0d", it), {r7, r6, r5, r4},
          {mrf[7][15:0], mrf[6][15:0], mrf[5][15:0], mrf[4][15:0]});
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_legv8.md
DATAPATH_LEGV8 -- requirements
Module: datapath_legv8

Interface
REQ-001 SHALL have no parameters; data width fixed at 64, register count 32, RAM depth 256 words of 64 bits.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, ports named as follows:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have the following register-file ports:
- DA  in  5  destination register index.
- SA  in  5  source A register index.
- SB  in  5  source B register index.
- W_reg  in  1  register write enable.
REQ-004 SHALL have the following ALU ports:
- FS  in  5  ALU function select.
- c_out  in  1  carry-in to the ALU adder.
- k  in  64  immediate constant.
- B_sel  in  1  ALU B-operand select: 1 = k, 0 = register B.
REQ-005 SHALL have the following RAM ports:
- addr  in  8  external RAM address.
- W_ram  in  1  RAM write enable.
- ram_en  in  1  RAM address source: 0 = addr, 1 = ALU result [7:0].
REQ-006 SHALL have the following bus-driver enables:
- alu_en  in  1  ALU result drives the bus.
- D_en  in  1  RAM read data drives the bus.
- B_en  in  1  register B data drives the bus.
REQ-007 SHALL have the following outputs:
- f  out  64  current internal data bus value.
- stat  out  4  ALU flags {V,C,N,Z}.
- r0..r7  out  16 each  bits [15:0] of registers X0..X7, for debug.

Function
REQ-008 Register file SHALL be 32x64 with two combinational read ports (SA→A, SB→B); index 31 SHALL always read 0 (XZR).
REQ-009 On a rising clk edge with W_reg=1 and DA≠31, register DA SHALL load the bus value f; writes to index 31 SHALL be discarded.
REQ-010 ALU operand A SHALL be register A; operand B SHALL be k when B_sel=1, else register B.
REQ-011 FS SHALL decode as {op[2:0], invA, invB}; invA/invB SHALL bitwise-invert A/B before the operation.
REQ-012 op SHALL select: 000 AND; 001 OR; 010 ADD (A+B+c_out); 011 XOR; 100 A<<B[5:0]; 101 A>>B[5:0] (logical); 110/111 result 0.
REQ-013 Subtraction SHALL be FS=01001 with c_out=1.
REQ-014 Flags SHALL be combinational from the ALU result:
- Z = (result==0).
- N = result[63].
- C = adder carry-out for ADD, else 0.
- V = signed overflow for ADD, else 0.
REQ-015 The bus SHALL be a priority mux, not tri-state: alu_en, then D_en, then B_en; 0 when none is set.
REQ-016 RAM read SHALL be combinational: mem[address] with the address selected per ram_en.
REQ-017 On a rising clk edge with W_ram=1, mem[address] SHALL load f.
REQ-018 A RAM read and write to the same address in one cycle SHALL read the old data.
REQ-019 A register read of DA while it is being written SHALL return the old value until the clock edge.
REQ-020 Address arithmetic SHALL wrap modulo 256; shifts by 64 or more SHALL yield 0.

Reset
REQ-021 rst=0 SHALL asynchronously clear all 32 registers to 0, so r0..r7 read 0.
REQ-022 RAM contents SHALL NOT be reset; a write coincident with an asserted reset SHALL be suppressed for registers and permitted for RAM.
REQ-023 Outputs SHALL be combinational functions of state and inputs, with no reset-specific override.

Structure
REQ-024 A shared package SHALL hold the ALU op encodings (AND, OR, ADD, XOR, LSL, LSR) and the constants XZR=31, DATA_W=64, RAM_AW=8.
REQ-025 The block SHALL contain one sub-module, alu_legv8 (operands, FS, carry-in → result, flags); the register file, RAM and bus mux SHALL be inline.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Reset: rst=0 after random writes -> r0..r7=0 and f=0 with all enables low.
- Store immediate: SA=31, k=1, FS=01000, B_sel=1, alu_en=1, W_ram=1, addr=0, one clock -> mem[0]=1, f=1, stat=0000.
- Load to register: D_en=1, addr=0, W_reg=1, DA=0, one clock -> r0=1.
- Fibonacci loop: SA=1, SB=0, FS=01000, B_sel=0, alu_en=1, W_reg=1, DA alternating 1/0 per cycle from X0=1, X1=0 -> r1,r0 sequence 1,2,3,5,8,13,...
- Subtract/flags: A=5, k=5, FS=01001, c_out=1, B_sel=1 -> f=0, stat Z=1, C=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, k=1 -> stat V=1, N=1.
- XZR: W_reg=1, DA=31 -> SA=31 still reads 0.
